const_mult_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer that shares one ConstMultMod unit (dual-lane a0/a1, mode, invert)

---
 rtl/const_mult_arbiter.sv | 142 ++++++++++++++
 tb/tb_const_mult_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/const_mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one ConstMultMod unit among NREQ requesters:
// latches the winner's operands, registers the unit's result and hands it back with valid/ready.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module const_mult_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1,
  parameter int unsigned W    = `WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_mode,
  input  logic [NREQ-1:0]      req_invert,
  input  logic [W*NREQ-1:0]    req_a0,
  input  logic [W*NREQ-1:0]    req_a1,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [W-1:0]         rsp_c0,
  output logic [W-1:0]         rsp_c1,
  output logic [1:0]           cm_mode,
  output logic                 cm_invert,
  output logic [W-1:0]         cm_a0,
  output logic [W-1:0]         cm_a1,
  input  logic [W-1:0]         cm_c0,
  input  logic [W-1:0]         cm_c1,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] last_q, last_d;
  logic [1:0]     cm_mode_q, cm_mode_d;
  logic           cm_invert_q, cm_invert_d;
  logic [W-1:0]   cm_a0_q, cm_a0_d;
  logic [W-1:0]   cm_a1_q, cm_a1_d;
  logic [W-1:0]   rsp_c0_q, rsp_c0_d;
  logic [W-1:0]   rsp_c1_q, rsp_c1_d;

  logic [NREQ-1:0] above_last, masked, pick, grant_oh, owner_oh;
  logic [IDW-1:0]  grant_idx;
  logic            any_req, owner_ready, arb_en, accept;

  // Requesters strictly after last get priority; if none are valid, wrap to the lowest index.
  // When last = NREQ-1 the shift overflows to zero, making above_last empty.
  assign above_last  = ~((NREQ'(1) << (32'(last_q) + 32'd1)) - NREQ'(1));
  assign masked      = req_valid & above_last;
  assign pick        = (|masked) ? masked : req_valid;
  assign grant_oh    = pick & (~pick + NREQ'(1));
  assign any_req     = |req_valid;
  assign owner_oh    = NREQ'(1) << owner_q;
  assign owner_ready = |(rsp_ready & owner_oh);

  for (genvar b = 0; b < IDW; b++) begin : g_enc
    logic [NREQ-1:0] bit_mask;
    for (genvar i = 0; i < NREQ; i++) begin : g_bit
      assign bit_mask[i] = ((i >> b) & 1) != 0;
    end
    assign grant_idx[b] = |(grant_oh & bit_mask);
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cm_mode_d   = cm_mode_q;
    cm_invert_d = cm_invert_q;
    cm_a0_d     = cm_a0_q;
    cm_a1_d     = cm_a1_q;
    rsp_c0_d    = rsp_c0_q;
    rsp_c1_d    = rsp_c1_q;
    arb_en      = 1'b0;

    case (state_q)
      IDLE: arb_en = 1'b1;
      CALC: begin
        rsp_c0_d = cm_c0;
        rsp_c1_d = cm_c1;
        state_d  = RESP;
      end
      RESP: begin
        if (owner_ready) begin
          arb_en  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    accept = arb_en && any_req;
    if (accept) begin
      state_d     = CALC;
      owner_d     = grant_idx;
      last_d      = grant_idx;
      cm_mode_d   = 2'(req_mode >> (32'd2 * 32'(grant_idx)));
      cm_invert_d = 1'(req_invert >> grant_idx);
      cm_a0_d     = W'(req_a0 >> (W * 32'(grant_idx)));
      cm_a1_d     = W'(req_a1 >> (W * 32'(grant_idx)));
    end

    req_ready = accept ? grant_oh : '0;
    rsp_valid = (state_q == RESP) ? owner_oh : '0;
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      last_q      <= IDW'(NREQ - 1);
      cm_mode_q   <= '0;
      cm_invert_q <= 1'b0;
      cm_a0_q     <= '0;
      cm_a1_q     <= '0;
      rsp_c0_q    <= '0;
      rsp_c1_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cm_mode_q   <= cm_mode_d;
      cm_invert_q <= cm_invert_d;
      cm_a0_q     <= cm_a0_d;
      cm_a1_q     <= cm_a1_d;
      rsp_c0_q    <= rsp_c0_d;
      rsp_c1_q    <= rsp_c1_d;
    end
  end

  assign cm_mode   = cm_mode_q;
  assign cm_invert = cm_invert_q;
  assign cm_a0     = cm_a0_q;
  assign cm_a1     = cm_a1_q;
  assign rsp_c0    = rsp_c0_q;
  assign rsp_c1    = rsp_c1_q;

endmodule

// File: tb/tb_const_mult_arbiter.sv
// Directed bench for const_mult_arbiter: a 2-requester and a 3-requester instance, each
// driving a stub unit computing c0 = a0 + 1, c1 = a1 + 2.
module tb_const_mult_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit odd;

  // Two-requester instance
  logic [1:0]  rv2, rr2, ri2, sv2, sr2;
  logic [3:0]  rm2;
  logic [31:0] ra0_2, ra1_2;
  logic [15:0] c0_2, c1_2, cma0_2, cma1_2, cmc0_2, cmc1_2;
  logic [1:0]  cmm2;
  logic        cmi2, busy2;

  assign cmc0_2 = cma0_2 + 16'd1;
  assign cmc1_2 = cma1_2 + 16'd2;

  const_mult_arbiter #(.NREQ(2), .IDW(1), .W(16)) u2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv2), .req_ready(rr2), .req_mode(rm2), .req_invert(ri2),
    .req_a0(ra0_2), .req_a1(ra1_2),
    .rsp_valid(sv2), .rsp_ready(sr2), .rsp_c0(c0_2), .rsp_c1(c1_2),
    .cm_mode(cmm2), .cm_invert(cmi2), .cm_a0(cma0_2), .cm_a1(cma1_2),
    .cm_c0(cmc0_2), .cm_c1(cmc1_2), .busy(busy2)
  );

  // Three-requester instance
  logic [2:0]  rv3, rr3, ri3, sv3, sr3;
  logic [5:0]  rm3;
  logic [47:0] ra0_3, ra1_3;
  logic [15:0] c0_3, c1_3, cma0_3, cma1_3, cmc0_3, cmc1_3;
  logic [1:0]  cmm3;
  logic        cmi3, busy3;

  assign cmc0_3 = cma0_3 + 16'd1;
  assign cmc1_3 = cma1_3 + 16'd2;

  const_mult_arbiter #(.NREQ(3), .IDW(2), .W(16)) u3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv3), .req_ready(rr3), .req_mode(rm3), .req_invert(ri3),
    .req_a0(ra0_3), .req_a1(ra1_3),
    .rsp_valid(sv3), .rsp_ready(sr3), .rsp_c0(c0_3), .rsp_c1(c1_3),
    .cm_mode(cmm3), .cm_invert(cmi3), .cm_a0(cma0_3), .cm_a1(cma1_3),
    .cm_c0(cmc0_3), .cm_c1(cmc1_3), .busy(busy3)
  );

  logic seen1 = 1'b0;
  always @(posedge clk) if (rr3[1]) seen1 <= 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rv2 = '0; rm2 = '0; ri2 = '0; ra0_2 = '0; ra1_2 = '0; sr2 = '0;
    rv3 = '0; rm3 = '0; ri3 = '0; ra0_3 = '0; ra1_3 = '0; sr3 = '0;
    tick();
    tick();
    chk("rst_busy", busy2, 1'b0);
    chk("rst_rsp_valid", sv2, 2'b00);
    chk("rst_cm_mode", cmm2, 2'd0);
    chk("rst_cm_invert", cmi2, 1'b0);
    chk("rst_cm_a0", cma0_2, 16'h0);
    chk("rst_cm_a1", cma1_2, 16'h0);
    chk("rst_rsp_c0", c0_2, 16'h0);
    chk("rst_rsp_c1", c1_2, 16'h0);
    chk("rst_busy3", busy3, 1'b0);
    rst_n = 1'b1;

    // Single request from requester 0
    rv2 = 2'b01; rm2 = 4'b0010; ri2 = 2'b01;
    ra0_2 = 32'h0000_0005; ra1_2 = 32'h0000_0009; sr2 = 2'b01;
    #1;
    chk("t1_req_ready", rr2, 2'b01);
    tick();
    chk("t1_cm_mode", cmm2, 2'd2);
    chk("t1_cm_invert", cmi2, 1'b1);
    chk("t1_cm_a0", cma0_2, 16'd5);
    chk("t1_cm_a1", cma1_2, 16'd9);
    chk("t1_busy_calc", busy2, 1'b1);
    chk("t1_rsp_valid_calc", sv2, 2'b00);
    rv2 = 2'b00;
    tick();
    chk("t1_rsp_valid", sv2, 2'b01);
    chk("t1_rsp_c0", c0_2, 16'd6);
    chk("t1_rsp_c1", c1_2, 16'd11);
    tick();
    chk("t1_idle_busy", busy2, 1'b0);
    chk("t1_idle_rsp_valid", sv2, 2'b00);

    // Both requesters continuously valid, starting from reset pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rv2 = 2'b11; rm2 = 4'b1101; ri2 = 2'b10;
    ra0_2 = 32'h0030_0010; ra1_2 = 32'h0040_0020; sr2 = 2'b11;
    #1;
    chk("t2_first_grant", rr2, 2'b01);
    tick();
    for (int unsigned k = 0; k < 4; k++) begin
      odd = (k % 2 == 1);
      chk("t2_calc_req_ready", rr2, 2'b00);
      chk("t2_calc_busy", busy2, 1'b1);
      chk("t2_cm_a0", cma0_2, (odd ? 16'h30 : 16'h10));
      chk("t2_cm_mode", cmm2, (odd ? 2'd3 : 2'd1));
      tick();
      chk("t2_rsp_valid", sv2, (odd ? 2'b10 : 2'b01));
      chk("t2_rsp_c0", c0_2, (odd ? 16'h31 : 16'h11));
      chk("t2_rsp_c1", c1_2, (odd ? 16'h42 : 16'h22));
      chk("t2_resp_busy", busy2, 1'b1);
      chk("t2_next_grant", rr2, (odd ? 2'b01 : 2'b10));
      tick();
    end

    // Backpressure on owner 0
    sr2 = 2'b00;
    tick();
    for (int unsigned k = 0; k < 5; k++) begin
      chk("t3_rsp_valid", sv2, 2'b01);
      chk("t3_rsp_c0", c0_2, 16'h11);
      chk("t3_rsp_c1", c1_2, 16'h22);
      chk("t3_req_ready", rr2, 2'b00);
      tick();
    end

    // Ready from the non-owner only is ignored
    sr2 = 2'b10;
    #1;
    for (int unsigned k = 0; k < 3; k++) begin
      chk("t4_rsp_valid", sv2, 2'b01);
      chk("t4_busy", busy2, 1'b1);
      chk("t4_req_ready", rr2, 2'b00);
      tick();
    end
    sr2 = 2'b01;
    #1;
    chk("t4_release_grant", rr2, 2'b10);
    tick();
    chk("t4_owner1_a0", cma0_2, 16'h30);
    rv2 = 2'b00; sr2 = 2'b11;
    tick();
    chk("t4_owner1_rsp_valid", sv2, 2'b10);
    chk("t4_owner1_c0", c0_2, 16'h31);
    tick();
    chk("t4_back_idle", busy2, 1'b0);

    // Reset while in CALC
    rv2 = 2'b01;
    #1;
    chk("t5_grant0", rr2, 2'b01);
    tick();
    chk("t5_in_calc", busy2, 1'b1);
    rv2 = 2'b00; rst_n = 1'b0;
    tick();
    chk("t5_rst_busy", busy2, 1'b0);
    chk("t5_rst_rsp_valid", sv2, 2'b00);
    chk("t5_rst_cm_a0", cma0_2, 16'h0);
    rst_n = 1'b1;
    tick();
    chk("t5_no_late_rsp", sv2, 2'b00);
    chk("t5_still_idle", busy2, 1'b0);
    rv2 = 2'b11;
    #1;
    chk("t5_first_grant", rr2, 2'b01);
    tick();
    chk("t5_cm_a0", cma0_2, 16'h10);
    rv2 = 2'b00;
    tick();
    tick();
    chk("t5_done", busy2, 1'b0);

    // Three requesters: 2 precedes 0 once last = 0
    rv3 = 3'b001; sr3 = 3'b111;
    ra0_3 = 48'h0300_0200_0100; ra1_3 = 48'h0030_0020_0010;
    #1;
    chk("t6_first_grant", rr3, 3'b001);
    tick();
    chk("t6_cm_a0_r0", cma0_3, 16'h100);
    rv3 = 3'b101;
    tick();
    chk("t6_rsp_valid_r0", sv3, 3'b001);
    chk("t6_grant_r2", rr3, 3'b100);
    tick();
    chk("t6_cm_a0_r2", cma0_3, 16'h300);
    chk("t6_calc_ready", rr3, 3'b000);
    tick();
    chk("t6_rsp_valid_r2", sv3, 3'b100);
    chk("t6_rsp_c0_r2", c0_3, 16'h301);
    chk("t6_rsp_c1_r2", c1_3, 16'h32);
    chk("t6_grant_r0_again", rr3, 3'b001);
    tick();
    chk("t6_cm_a0_r0_again", cma0_3, 16'h100);
    rv3 = 3'b000;
    tick();
    tick();
    chk("t6_idle", busy3, 1'b0);
    chk("t6_r1_never_ready", seen1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
